uart_tx_fifo: RTL

Byte buffer directly upstream of `uart_tx`. It accepts bytes from the application side in single-cycle writes and holds them in a power-of-two circular FIFO. It feeds them one at a time to `uart_tx` over the `TX_DRDY`/`TX_DI` handshake, using `TX_BUSY`/`TX_DONE` to pace itself. Producers can therefore burst up to `DEPTH` bytes without tracking the serializer's state.

---
 rtl/uart_tx_fifo.sv | 107 ++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of uart_tx: buffers application writes and hands bytes one
// at a time to the serializer over the TX_DRDY/TX_DI handshake.
//
// state     | meaning
// IDLE      | waiting for stored data and an idle serializer; pops on exit
// LOAD      | TX_DI holds the popped byte; TX_DRDY is raised on exit
// WAIT_BUSY | TX_DRDY held until uart_tx reports TX_BUSY
// WAIT_DONE | frame in flight; waits for TX_DONE (or TX_BUSY dropping)
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16
) (
  input  logic                     CLK,
  input  logic                     NRST,
  input  logic                     WR_EN,
  input  logic [DATA_BITS-1:0]     WR_DATA,
  input  logic                     FLUSH,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     OVERFLOW,
  output logic                     TX_DRDY,
  output logic [DATA_BITS-1:0]     TX_DI,
  input  logic                     TX_BUSY,
  input  logic                     TX_DONE
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

  state_t               state, state_nxt;
  logic [AW:0]          wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic                 pop, wr_ok, drdy_nxt;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign EMPTY = (wr_ptr == rd_ptr);
  assign FULL  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign LEVEL = wr_ptr - rd_ptr;
  assign wr_ok = WR_EN && !FULL && !FLUSH;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    drdy_nxt  = TX_DRDY;
    case (state)
      IDLE: begin
        if (!EMPTY && !TX_BUSY && !FLUSH) begin
          pop       = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        drdy_nxt  = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (TX_BUSY) begin
          drdy_nxt  = 1'b0;
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // Entry requires TX_BUSY high, so a low level here means it fell.
        if (TX_DONE || !TX_BUSY)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state    <= IDLE;
      TX_DRDY  <= 1'b0;
      TX_DI    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      state   <= state_nxt;
      TX_DRDY <= drdy_nxt;
      if (pop)
        TX_DI <= mem[rd_ptr[AW-1:0]];
      if (FLUSH) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        OVERFLOW <= 1'b0;
      end else begin
        if (wr_ok)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        if (WR_EN && FULL)
          OVERFLOW <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_ok)
      mem[wr_ptr[AW-1:0]] <= WR_DATA;
  end

endmodule
